// File: rtl/ladybird_config.sv
// Shared widths and record types for the ladybird bus queue.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
package ladybird_config;

   localparam int XLEN = 32;

   // One queued bus request; we is derived from a non-zero strobe.
   typedef struct packed {
      logic              we;
      logic [XLEN/8-1:0] wstrb;
      logic [XLEN-1:0]   addr;
      logic [XLEN-1:0]   data;
   } request_t;

   // One completed transaction waiting for the consumer.
   typedef struct packed {
      logic            we;
      logic [XLEN-1:0] data;
   } response_t;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_ADDR = 2'd1,
      ST_DATA = 2'd2
   } issue_state_t;

endpackage

// File: rtl/ladybird_fifo.sv
// Generic in-order FIFO with wrap-bit pointers and an occupancy count.
// Latency: a push is visible at pop_dat_o the cycle after it is written.
// Backpressure: push ignored when full, pop ignored when empty.
module ladybird_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push_i,
   input  logic [WIDTH-1:0]         push_dat_i,
   input  logic                     pop_i,
   output logic [WIDTH-1:0]         pop_dat_o,
   output logic                     full_o,
   output logic                     empty_o,
   output logic [$clog2(DEPTH):0]   count_o
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW:0]      wr_ptr_q, wr_ptr_d;
   logic [AW:0]      rd_ptr_q, rd_ptr_d;
   logic             do_push, do_pop;

   // Same index with differing wrap bits means the write side has lapped the read side.
   assign empty_o   = (wr_ptr_q == rd_ptr_q);
   assign full_o    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                      (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
   assign count_o   = wr_ptr_q - rd_ptr_q;
   assign pop_dat_o = mem_q[rd_ptr_q[AW-1:0]];
   assign do_push   = push_i & ~full_o;
   assign do_pop    = pop_i & ~empty_o;

   // Advance each pointer by one on an effective push or pop.
   always_comb begin
      wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, do_push};
      rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, do_pop};
   end

   // Pointer registers; reset empties the queue.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
      end
   end

   // Storage array; contents need no reset since the pointers gate visibility.
   always_ff @(posedge clk) begin
      if (do_push) begin
         mem_q[wr_ptr_q[AW-1:0]] <= push_dat_i;
      end
   end

endmodule

// File: rtl/ladybird_bus_queue.sv
// Queues requests, issues them one at a time on a split addr/data bus, queues responses.
// Latency: accept at N -> bus_req at N+1 -> earliest o_valid at N+3.
// Backpressure: i_ready drops when the request queue is full; issue waits for response credit.
module ladybird_bus_queue
   import ladybird_config::*;
#(
   parameter int DEPTH      = 4,
   parameter bit SIMULATION = 1'b0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              i_valid,
   output logic              i_ready,
   input  logic [XLEN-1:0]   i_addr,
   input  logic [XLEN-1:0]   i_data,
   input  logic [XLEN/8-1:0] i_wstrb,
   output logic              o_valid,
   input  logic              o_ready,
   output logic [XLEN-1:0]   o_data,
   output logic              o_we,
   output logic              bus_req,
   input  logic              bus_gnt,
   output logic [XLEN-1:0]   bus_addr,
   inout  wire  [XLEN-1:0]   bus_data,
   output logic [XLEN/8-1:0] bus_wstrb,
   input  logic              bus_data_gnt
);

   localparam int AW = $clog2(DEPTH);

   request_t     req_in, req_head;
   response_t    resp_in, resp_head;
   logic         req_push, req_pop, req_full, req_empty;
   logic         resp_push, resp_pop, resp_empty;
   logic         resp_full_unused;
   logic [AW:0]  req_count_unused;
   logic [AW:0]  resp_count;
   issue_state_t state_q, state_d;
   logic         inflight_q, inflight_d;
   logic         we_q, we_d;
   logic         credit;
   logic         data_oe;

   assign req_in   = '{we: |i_wstrb, wstrb: i_wstrb, addr: i_addr, data: i_data};
   assign i_ready  = ~req_full;
   assign req_push = i_valid & i_ready;

   ladybird_fifo #(.WIDTH($bits(request_t)), .DEPTH(DEPTH)) u_req_fifo (
      .clk        (clk),
      .rst        (rst),
      .push_i     (req_push),
      .push_dat_i (req_in),
      .pop_i      (req_pop),
      .pop_dat_o  (req_head),
      .full_o     (req_full),
      .empty_o    (req_empty),
      .count_o    (req_count_unused)
   );

   // A transaction may only start if its data_gnt is guaranteed a response slot.
   assign credit = (int'(resp_count) + int'(inflight_q)) < DEPTH;

   // Issue sequencing and bus outputs; an incoming push counts as non-empty so
   // a request accepted into an idle queue reaches the bus on the next cycle.
   always_comb begin
      state_d    = state_q;
      inflight_d = inflight_q;
      we_d       = we_q;
      req_pop    = 1'b0;
      resp_push  = 1'b0;
      bus_req    = 1'b0;
      bus_addr   = '0;
      bus_wstrb  = '0;
      data_oe    = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if ((!req_empty || req_push) && credit) begin
               state_d    = ST_ADDR;
               inflight_d = 1'b1;
            end
         end
         ST_ADDR: begin
            bus_req   = 1'b1;
            bus_addr  = req_head.addr;
            bus_wstrb = req_head.wstrb;
            data_oe   = req_head.we;
            if (bus_gnt) begin
               state_d = ST_DATA;
               req_pop = 1'b1;
               we_d    = req_head.we;
            end
         end
         ST_DATA: begin
            if (bus_data_gnt) begin
               state_d    = ST_IDLE;
               inflight_d = 1'b0;
               resp_push  = 1'b1;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // FSM, in-flight flag and latched direction of the transaction on the bus.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         inflight_q <= 1'b0;
         we_q       <= 1'b0;
      end else begin
         state_q    <= state_d;
         inflight_q <= inflight_d;
         we_q       <= we_d;
      end
   end

   // Write data is only driven while the address phase is presented.
   assign bus_data = data_oe ? req_head.data : {XLEN{1'bz}};

   // Write responses carry no data, so store zeros rather than a floating bus.
   assign resp_in  = '{we: we_q, data: (we_q ? {XLEN{1'b0}} : bus_data)};
   assign resp_pop = o_valid & o_ready;

   ladybird_fifo #(.WIDTH($bits(response_t)), .DEPTH(DEPTH)) u_resp_fifo (
      .clk        (clk),
      .rst        (rst),
      .push_i     (resp_push),
      .push_dat_i (resp_in),
      .pop_i      (resp_pop),
      .pop_dat_o  (resp_head),
      .full_o     (resp_full_unused),
      .empty_o    (resp_empty),
      .count_o    (resp_count)
   );

   assign o_valid = ~resp_empty;
   assign o_data  = resp_head.data;
   assign o_we    = o_valid & resp_head.we;

   generate
      if (SIMULATION) begin : g_sim_chk
         // Flag a data grant that arrives when no transaction is waiting for it.
         always_ff @(posedge clk) begin
            if (!rst) begin
               assert (!(bus_data_gnt && (state_q != ST_DATA)))
                  else $error("ladybird_bus_queue: data_gnt outside data phase");
            end
         end
      end
   endgenerate

endmodule

// File: tb/tb_ladybird_bus_queue.sv
// Directed bench for ladybird_bus_queue acting as bus target and response consumer.
// Latency: checks the N -> N+1 -> N+3 request/response timing.
// Backpressure: exercises request-full, response credit stall and o_ready toggling.
module tb_ladybird_bus_queue;
   import ladybird_config::*;

   logic              clk = 1'b0;
   logic              rst;
   logic              i_valid;
   logic              i_ready;
   logic [XLEN-1:0]   i_addr;
   logic [XLEN-1:0]   i_data;
   logic [XLEN/8-1:0] i_wstrb;
   logic              o_valid;
   logic              o_ready;
   logic [XLEN-1:0]   o_data;
   logic              o_we;
   logic              bus_req;
   logic              bus_gnt;
   logic [XLEN-1:0]   bus_addr;
   wire  [XLEN-1:0]   bus_data;
   logic [XLEN/8-1:0] bus_wstrb;
   logic              bus_data_gnt;

   logic              tb_drv;
   logic [XLEN-1:0]   tb_val;
   logic              collect_en;
   logic              toggle_en;
   logic [XLEN-1:0]   got [$];
   int                total = 0;
   int                bad   = 0;

   // Bench side of the shared data bus: it drives 0 while the DUT must be off,
   // so any DUT drive then shows up as a non-zero or unknown value.
   assign bus_data = tb_drv ? tb_val : {XLEN{1'bz}};

   always #5 clk = ~clk;

   ladybird_bus_queue #(.DEPTH(4), .SIMULATION(1'b0)) dut (
      .clk          (clk),
      .rst          (rst),
      .i_valid      (i_valid),
      .i_ready      (i_ready),
      .i_addr       (i_addr),
      .i_data       (i_data),
      .i_wstrb      (i_wstrb),
      .o_valid      (o_valid),
      .o_ready      (o_ready),
      .o_data       (o_data),
      .o_we         (o_we),
      .bus_req      (bus_req),
      .bus_gnt      (bus_gnt),
      .bus_addr     (bus_addr),
      .bus_data     (bus_data),
      .bus_wstrb    (bus_wstrb),
      .bus_data_gnt (bus_data_gnt)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp)
         else begin
            bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
         end
   endtask

   // One clock: sample a response handshake just before the edge, then settle after it.
   task automatic step();
      #1;
      if (collect_en && o_valid && o_ready) got.push_back(o_data);
      @(posedge clk);
      #1;
      if (toggle_en) o_ready = ~o_ready;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1; i_valid = 1'b0; i_addr = '0; i_data = '0; i_wstrb = '0;
      o_ready = 1'b0; bus_gnt = 1'b0; bus_data_gnt = 1'b0;
      tb_drv = 1'b1; tb_val = '0; collect_en = 1'b0; toggle_en = 1'b0;

      // Reset state
      step(); step();
      chk("rst_i_ready", 64'(i_ready), 64'(1));
      chk("rst_o_valid", 64'(o_valid), 64'(0));
      chk("rst_o_we",    64'(o_we),    64'(0));
      chk("rst_req",     64'(bus_req), 64'(0));
      chk("rst_wstrb",   64'(bus_wstrb), 64'(0));
      chk("rst_data_z",  64'(bus_data), 64'(0));
      rst = 1'b0;
      step();

      // Read 0x100, target returns 0xDEADBEEF one cycle after gnt
      i_valid = 1'b1; i_addr = 32'h100; i_data = 32'hCAFEF00D; i_wstrb = 4'b0000;
      step();
      i_valid = 1'b0;
      chk("rd_req",      64'(bus_req),   64'(1));
      chk("rd_addr",     64'(bus_addr),  64'(32'h100));
      chk("rd_wstrb",    64'(bus_wstrb), 64'(0));
      chk("rd_data_z",   64'(bus_data),  64'(0));
      bus_gnt = 1'b1;
      step();
      bus_gnt = 1'b0;
      chk("rd_req_data", 64'(bus_req), 64'(0));
      chk("rd_nvalid",   64'(o_valid), 64'(0));
      bus_data_gnt = 1'b1; tb_val = 32'hDEADBEEF;
      step();
      bus_data_gnt = 1'b0; tb_val = '0;
      chk("rd_o_valid",  64'(o_valid), 64'(1));
      chk("rd_o_data",   64'(o_data),  64'(32'hDEADBEEF));
      chk("rd_o_we",     64'(o_we),    64'(0));
      o_ready = 1'b1;
      step();
      o_ready = 1'b0;
      chk("rd_popped",   64'(o_valid), 64'(0));

      // Write 0x204 with upper-half strobes
      i_valid = 1'b1; i_addr = 32'h204; i_data = 32'h11223344; i_wstrb = 4'b1100;
      tb_drv = 1'b0;
      step();
      i_valid = 1'b0;
      chk("wr_req",      64'(bus_req),   64'(1));
      chk("wr_addr",     64'(bus_addr),  64'(32'h204));
      chk("wr_wstrb",    64'(bus_wstrb), 64'(4'b1100));
      chk("wr_data",     64'(bus_data),  64'(32'h11223344));
      bus_gnt = 1'b1;
      step();
      bus_gnt = 1'b0; tb_drv = 1'b1; tb_val = '0;
      #1;
      chk("wr_data_z",   64'(bus_data),  64'(0));
      chk("wr_wstrb_0",  64'(bus_wstrb), 64'(0));
      bus_data_gnt = 1'b1;
      step();
      bus_data_gnt = 1'b0;
      chk("wr_o_valid",  64'(o_valid), 64'(1));
      chk("wr_o_we",     64'(o_we),    64'(1));
      o_ready = 1'b1;
      step();
      o_ready = 1'b0;
      chk("wr_popped",   64'(o_valid), 64'(0));

      // Full request queue with gnt held low: 4 of 5 accepted
      i_wstrb = 4'b0000;
      for (int k = 0; k < 5; k++) begin
         i_valid = 1'b1; i_addr = 32'h40 + 32'(k) * 32'h10; i_data = 32'hA0 + 32'(k);
         #1;
         chk("full_i_ready", 64'(i_ready), 64'((k < 4) ? 1 : 0));
         step();
      end
      i_valid = 1'b0;
      chk("full_head",   64'(bus_addr), 64'(32'h40));
      bus_gnt = 1'b1; bus_data_gnt = 1'b1; tb_val = 32'h5A5A5A5A;
      for (int c = 0; c < 12; c++) step();
      bus_gnt = 1'b0; bus_data_gnt = 1'b0; tb_val = '0;
      chk("full_drained_rdy", 64'(i_ready), 64'(1));
      chk("full_resp_vld",    64'(o_valid), 64'(1));
      // Response queue is full: a new request must not be issued
      i_valid = 1'b1; i_addr = 32'h90; i_data = 32'hB0;
      step();
      i_valid = 1'b0;
      chk("credit_stall0", 64'(bus_req), 64'(0));
      step();
      chk("credit_stall1", 64'(bus_req), 64'(0));
      bus_gnt = 1'b1;
      o_ready = 1'b1;
      step();
      o_ready = 1'b0;
      chk("credit_stall2", 64'(bus_req), 64'(0));
      step();
      chk("credit_issue",  64'(bus_req),  64'(1));
      chk("credit_addr",   64'(bus_addr), 64'(32'h90));
      bus_data_gnt = 1'b1; tb_val = 32'h5A5A5A5A;
      step(); step();
      bus_gnt = 1'b0; bus_data_gnt = 1'b0; tb_val = '0;
      got.delete();
      collect_en = 1'b1; o_ready = 1'b1;
      for (int c = 0; c < 8; c++) step();
      collect_en = 1'b0; o_ready = 1'b0;
      chk("full_resp_cnt", 64'(got.size()), 64'(4));
      chk("full_resp_dat", 64'(got[0]), 64'(32'h5A5A5A5A));
      chk("full_empty",    64'(o_valid), 64'(0));

      // Ordering: three reads with o_ready toggling every cycle
      got.delete();
      collect_en = 1'b1; toggle_en = 1'b1;
      for (int j = 0; j < 3; j++) begin
         i_valid = 1'b1; i_addr = 32'(4 * j); i_data = 32'hC0 + 32'(j);
         step();
      end
      i_valid = 1'b0;
      for (int j = 0; j < 3; j++) begin
         for (int w = 0; w < 6 && !bus_req; w++) step();
         chk("ord_req",  64'(bus_req),  64'(1));
         chk("ord_addr", 64'(bus_addr), 64'(4 * j));
         bus_gnt = 1'b1;
         step();
         bus_gnt = 1'b0; bus_data_gnt = 1'b1; tb_val = 32'h1000 + 32'(4 * j);
         step();
         bus_data_gnt = 1'b0; tb_val = '0;
      end
      for (int c = 0; c < 10; c++) step();
      collect_en = 1'b0; toggle_en = 1'b0; o_ready = 1'b0;
      chk("ord_cnt", 64'(got.size()), 64'(3));
      for (int j = 0; j < 3; j++) chk("ord_dat", 64'(got[j]), 64'(32'h1000 + 4 * j));

      // Reset while in the data phase with a second request still queued
      i_valid = 1'b1; i_addr = 32'h300; i_data = 32'hD0;
      step();
      i_addr = 32'h304; bus_gnt = 1'b1;
      step();
      i_valid = 1'b0; bus_gnt = 1'b0;
      chk("rdat_req_off", 64'(bus_req), 64'(0));
      rst = 1'b1;
      step();
      rst = 1'b0;
      chk("rdat_i_ready", 64'(i_ready), 64'(1));
      chk("rdat_o_valid", 64'(o_valid), 64'(0));
      bus_data_gnt = 1'b1; tb_val = 32'h00000BAD;
      step();
      bus_data_gnt = 1'b0; tb_val = '0;
      step();
      chk("stray_o_valid", 64'(o_valid), 64'(0));
      chk("stray_req",     64'(bus_req), 64'(0));
      step();
      chk("stray_req2",    64'(bus_req), 64'(0));
      chk("stray_o_we",    64'(o_we),    64'(0));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
